// File: rtl/ddr_test_axi_traffic.sv
// ddr_test_axi_traffic: writes a deterministic pattern over a DDR window via AXI, reads it back and checks every beat.
// Loops forever after init; exports a sticky error flag plus saturating error and wrapping pass counters.
module ddr_test_axi_traffic #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int BURST_LEN = 16,
  parameter int NUM_BURST = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    core_clk,
  input  logic                    core_rst,
  input  logic                    ddr_init_done,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  output logic                    err_flag,
  output logic [15:0]             err_cnt,
  output logic [15:0]             loop_cnt,
  output logic                    test_busy
);
  localparam logic [7:0] LAST = 8'(BURST_LEN - 1);
  localparam logic [15:0] BMAX = 16'(NUM_BURST - 1);
  localparam logic [15:0] BL16 = 16'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, LOOP} state_t;
  state_t state_q, state_d;
  logic [15:0] b_q, b_d, loop_q, loop_d, err_cnt_q, err_cnt_d, word;
  logic [7:0] beat_q, beat_d;
  logic err_q, err_d, sync1_q, sync2_q, last_beat, beat_err;
  logic [DATA_WIDTH-1:0] pattern;
  logic [ADDR_WIDTH-1:0] burst_addr;
  // Word index wraps at 16 bits, so the pattern repeats for windows beyond 64K beats.
  assign word = b_q * BL16 + {8'd0, beat_q};
  assign pattern = {(DATA_WIDTH / 32){loop_q, word}};
  assign last_beat = beat_q == LAST;
  assign burst_addr = BASE_ADDR + ADDR_WIDTH'(b_q) * STRIDE;
  assign test_busy = state_q != IDLE;
  assign axi_awaddr = test_busy ? burst_addr : '0;
  assign axi_araddr = test_busy ? burst_addr : '0;
  assign axi_awlen = LAST;
  assign axi_arlen = LAST;
  assign axi_awvalid = state_q == WR_ADDR;
  assign axi_wvalid = state_q == WR_DATA;
  assign axi_wdata = pattern;
  assign axi_wstrb = '1;
  assign axi_wlast = axi_wvalid && last_beat;
  assign axi_arvalid = state_q == RD_ADDR;
  assign axi_rready = state_q == RD_DATA;
  assign err_flag = err_q;
  assign err_cnt = err_cnt_q;
  assign loop_cnt = loop_q;
  // A data and an rlast failure on the same beat still count once.
  assign beat_err = axi_rready && axi_rvalid && ((axi_rdata != pattern) || (axi_rlast != last_beat));
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q <= IDLE;
      b_q <= '0;
      beat_q <= '0;
      loop_q <= '0;
      err_cnt_q <= '0;
      err_q <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q <= b_d;
      beat_q <= beat_d;
      loop_q <= loop_d;
      err_cnt_q <= err_cnt_d;
      err_q <= err_d;
      sync1_q <= ddr_init_done;
      sync2_q <= sync1_q;
    end
  end
  always_comb begin
    state_d = state_q;
    b_d = b_q;
    beat_d = beat_q;
    loop_d = loop_q;
    err_d = err_q | beat_err;
    err_cnt_d = err_cnt_q + {15'd0, beat_err && err_cnt_q != 16'hFFFF};
    case (state_q)
      IDLE: if (sync2_q) begin
        state_d = WR_ADDR;
        b_d = '0;
      end
      WR_ADDR: if (axi_awready) begin
        state_d = WR_DATA;
        beat_d = '0;
      end
      WR_DATA: if (axi_wready) begin
        beat_d = beat_q + 8'd1;
        if (last_beat) begin
          state_d = (b_q == BMAX) ? RD_ADDR : WR_ADDR;
          b_d = (b_q == BMAX) ? '0 : b_q + 16'd1;
        end
      end
      RD_ADDR: if (axi_arready) begin
        state_d = RD_DATA;
        beat_d = '0;
      end
      RD_DATA: if (axi_rvalid) begin
        beat_d = beat_q + 8'd1;
        if (last_beat) begin
          state_d = (b_q == BMAX) ? LOOP : RD_ADDR;
          b_d = (b_q == BMAX) ? b_q : b_q + 16'd1;
        end
      end
      LOOP: begin
        state_d = WR_ADDR;
        b_d = '0;
        loop_d = loop_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ddr_test_axi_traffic.sv
// tb_ddr_test_axi_traffic: ideal AXI memory responder with stalls and read faults; write beats checked from a scoreboard.
module tb_ddr_test_axi_traffic;
  localparam int AW = 28, DW = 64, BL = 4, NB = 2;
  logic core_clk = 0, core_rst = 1, ddr_init_done = 0;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [7:0] axi_awlen, axi_arlen;
  logic axi_awvalid, axi_awready = 0, axi_wlast, axi_wvalid, axi_wready = 0;
  logic axi_arvalid, axi_arready = 0, axi_rlast = 0, axi_rvalid = 0, axi_rready;
  logic [DW-1:0] axi_wdata, axi_rdata = '0;
  logic [DW/8-1:0] axi_wstrb;
  logic err_flag, test_busy;
  logic [15:0] err_cnt, loop_cnt;
  always #5 core_clk = ~core_clk;
  ddr_test_axi_traffic #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .NUM_BURST(NB), .BASE_ADDR(28'd0)) dut (
    .core_clk(core_clk), .core_rst(core_rst), .ddr_init_done(ddr_init_done),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .err_flag(err_flag), .err_cnt(err_cnt), .loop_cnt(loop_cnt), .test_busy(test_busy)
  );
  typedef struct {logic [63:0] d; logic l;} wexp_t;
  typedef struct {int stall; logic [63:0] d; logic l;} vec_t;
  wexp_t sb[$];
  vec_t tbl[8];
  logic [63:0] mem[64];
  int checks = 0, errors = 0, exp_cnt = 0, wptr = 0, rptr = 0;
  logic exp_flag = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] pat(input int p, input int w);
    return {p[15:0], w[15:0], p[15:0], w[15:0]};
  endfunction
  function automatic logic vsig(input int c);
    return c == 0 ? axi_awvalid : c == 1 ? axi_wvalid : axi_arvalid;
  endfunction
  task automatic wait_valid(input int c, input string nm);
    int t = 0;
    while (!vsig(c) && t < 200) begin
      @(negedge core_clk);
      t++;
    end
    chk({nm, "_arrives"}, 64'(vsig(c)), 64'd1);
  endtask
  task automatic aw_hs(input int p, input int b, input int stall);
    wait_valid(0, "awvalid");
    chk("loop_cnt", 64'(loop_cnt), 64'(p));
    chk("aw_w_excl", 64'(axi_wvalid), 64'd0);
    repeat (stall) begin
      @(negedge core_clk);
      chk("awvalid_held", 64'(axi_awvalid), 64'd1);
    end
    chk("awaddr", 64'(axi_awaddr), 64'(b * 32));
    chk("awlen", 64'(axi_awlen), 64'd3);
    wptr = int'(axi_awaddr >> 3);
    for (int k = 0; k < BL; k++) sb.push_back('{pat(p, b * BL + k), k == BL - 1});
    axi_awready = 1;
    @(negedge core_clk);
    axi_awready = 0;
  endtask
  task automatic w_beat(input int stall);
    wexp_t e;
    wait_valid(1, "wvalid");
    e = sb.pop_front();
    chk("wdata", axi_wdata, e.d);
    chk("wlast", 64'(axi_wlast), 64'(e.l));
    chk("wstrb", 64'(axi_wstrb), 64'hFF);
    chk("w_aw_excl", 64'(axi_awvalid), 64'd0);
    repeat (stall) @(negedge core_clk);
    if (stall > 0) begin
      chk("wdata_stall", axi_wdata, e.d);
      chk("wlast_stall", 64'(axi_wlast), 64'(e.l));
    end
    mem[wptr % 64] = axi_wdata;
    wptr++;
    axi_wready = 1;
    @(negedge core_clk);
    axi_wready = 0;
  endtask
  task automatic ar_hs(input int b, input int stall);
    wait_valid(2, "arvalid");
    repeat (stall) begin
      @(negedge core_clk);
      chk("arvalid_held", 64'(axi_arvalid), 64'd1);
    end
    chk("araddr", 64'(axi_araddr), 64'(b * 32));
    chk("arlen", 64'(axi_arlen), 64'd3);
    chk("ar_aw_excl", 64'(axi_awvalid | axi_wvalid), 64'd0);
    rptr = int'(axi_araddr >> 3);
    axi_arready = 1;
    @(negedge core_clk);
    axi_arready = 0;
  endtask
  task automatic r_beat(input int k, input int stall, input logic [63:0] flip, input logic badlast);
    repeat (stall) @(negedge core_clk);
    chk("rready", 64'(axi_rready), 64'd1);
    chk("r_ar_excl", 64'(axi_arvalid), 64'd0);
    axi_rdata = mem[rptr % 64] ^ flip;
    axi_rlast = (k == BL - 1) || badlast;
    axi_rvalid = 1;
    @(negedge core_clk);
    axi_rvalid = 0;
    axi_rlast = 0;
    rptr++;
    if (flip != 0 || badlast) begin
      exp_flag = 1;
      if (exp_cnt < 65535) exp_cnt++;
    end
    chk("err_flag", 64'(err_flag), 64'(exp_flag));
    chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
  endtask
  task automatic run_pass(input int p, input int smax, input int cw, input int lw);
    for (int b = 0; b < NB; b++) begin
      aw_hs(p, b, $urandom_range(smax, 0));
      for (int k = 0; k < BL; k++) w_beat($urandom_range(smax, 0));
    end
    for (int b = 0; b < NB; b++) begin
      ar_hs(b, $urandom_range(smax, 0));
      for (int k = 0; k < BL; k++)
        r_beat(k, $urandom_range(smax, 0), (b * BL + k == cw) ? 64'h1 : 64'h0, b * BL + k == lw);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
  initial begin
    int t, idle_bad;
    tbl[0] = '{0, 64'h0000_0000_0000_0000, 1'b0};
    tbl[1] = '{1, 64'h0000_0001_0000_0001, 1'b0};
    tbl[2] = '{0, 64'h0000_0002_0000_0002, 1'b0};
    tbl[3] = '{3, 64'h0000_0003_0000_0003, 1'b1};
    tbl[4] = '{2, 64'h0000_0004_0000_0004, 1'b0};
    tbl[5] = '{0, 64'h0000_0005_0000_0005, 1'b0};
    tbl[6] = '{1, 64'h0000_0006_0000_0006, 1'b0};
    tbl[7] = '{0, 64'h0000_0007_0000_0007, 1'b1};
    repeat (3) @(negedge core_clk);
    chk("rst_valids", 64'({axi_awvalid, axi_wvalid, axi_arvalid, axi_rready, axi_wlast}), 64'd0);
    chk("rst_busy", 64'(test_busy), 64'd0);
    chk("rst_counts", 64'({err_flag, err_cnt, loop_cnt}), 64'd0);
    chk("rst_addr_data", 64'(axi_awaddr | axi_araddr) | axi_wdata, 64'd0);
    core_rst = 0;
    idle_bad = 0;
    repeat (100) begin
      @(negedge core_clk);
      if (axi_awvalid | axi_wvalid | axi_arvalid | axi_rready | test_busy) idle_bad++;
    end
    chk("idle_quiet", 64'(idle_bad), 64'd0);
    ddr_init_done = 1;
    t = 0;
    while (!axi_awvalid && t < 10) begin
      @(negedge core_clk);
      t++;
    end
    chk("start_within_4", 64'(axi_awvalid && t <= 4), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (i % BL == 0) begin
        aw_hs(0, i / BL, tbl[i].stall);
        sb.delete();
        for (int k = 0; k < BL; k++) sb.push_back('{tbl[i + k].d, tbl[i + k].l});
      end
      w_beat(tbl[i].stall);
    end
    for (int b = 0; b < NB; b++) begin
      ar_hs(b, 0);
      for (int k = 0; k < BL; k++) r_beat(k, 0, 64'h0, 1'b0);
    end
    run_pass(1, 5, -1, -1);
    run_pass(2, 5, -1, -1);
    wait_valid(0, "awvalid_pass3");
    chk("loop_cnt_3", 64'(loop_cnt), 64'd3);
    chk("clean_flag", 64'(err_flag), 64'd0);
    chk("clean_cnt", 64'(err_cnt), 64'd0);
    run_pass(3, 2, 5, -1);
    run_pass(4, 2, -1, -1);
    run_pass(5, 2, 2, 2);
    aw_hs(6, 0, 0);
    w_beat(0);
    w_beat(0);
    wait_valid(1, "wvalid_beat2");
    #2 core_rst = 1;
    #1;
    chk("arst_valids", 64'({axi_awvalid, axi_wvalid, axi_arvalid, axi_rready, axi_wlast}), 64'd0);
    chk("arst_busy", 64'(test_busy), 64'd0);
    chk("arst_counts", 64'({err_flag, err_cnt, loop_cnt}), 64'd0);
    chk("arst_addr_data", 64'(axi_awaddr | axi_araddr) | axi_wdata, 64'd0);
    sb.delete();
    exp_cnt = 0;
    exp_flag = 0;
    repeat (2) @(negedge core_clk);
    core_rst = 0;
    run_pass(0, 3, -1, -1);
    aw_hs(1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
